// File: rtl/gf180mcu_fd_io__brkn_seq.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_fd_io__brkn_seq
// Description : Power sequencer for NSEG pad-ring segments separated by break
//               cells. Ramps segment power switches on one at a time, spaced
//               by a settle delay, then releases isolation. Ramps down in
//               reverse order with isolation asserted first. A request drop
//               during ramp-up aborts and unwinds only the powered segments.
// Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_io__brkn_seq #(
    parameter  int NSEG    = 4,
    parameter  int SETTLE  = 16,
    parameter  int ISO_DLY = 4,
    localparam int IW      = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PWR_REQ,
    input  logic [NSEG-1:0] SEG_MASK,
    output logic [NSEG-1:0] SEG_ON,
    output logic [NSEG-1:0] ISO,
    output logic            READY,
    output logic            BUSY,
    output logic [IW-1:0]   SEG_IDX
);

    // Counter must hold the larger of the per-index settle time and the
    // isolation delay.
    localparam int c_CMAX = (SETTLE > ISO_DLY) ? SETTLE : ISO_DLY;
    localparam int c_CW   = $clog2(c_CMAX + 1);

    localparam logic [c_CW-1:0] c_ZERO       = '0;
    localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);
    localparam logic [c_CW-1:0] c_SETTLE     = c_CW'(SETTLE);
    localparam logic [c_CW-1:0] c_ISO_DLY    = c_CW'(ISO_DLY);
    localparam logic [c_CW-1:0] c_ISO_DLY_M1 = c_CW'(ISO_DLY - 1);
    localparam logic [IW-1:0]   c_LAST       = IW'(NSEG - 1);
    localparam logic [IW-1:0]   c_IDX0       = '0;

    localparam logic [2:0] c_ST_OFF        = 3'd0;
    localparam logic [2:0] c_ST_UP         = 3'd1;
    localparam logic [2:0] c_ST_ISO_REL    = 3'd2;
    localparam logic [2:0] c_ST_ON         = 3'd3;
    localparam logic [2:0] c_ST_ISO_ASSERT = 3'd4;
    localparam logic [2:0] c_ST_DOWN       = 3'd5;

    logic [2:0]      r_state,  w_state_nxt;
    logic [NSEG-1:0] r_mask,   w_mask_nxt;
    logic [IW-1:0]   r_idx,    w_idx_nxt;
    logic [c_CW-1:0] r_cnt,    w_cnt_nxt;
    logic [NSEG-1:0] r_seg_on, w_seg_on_nxt;
    logic [NSEG-1:0] r_iso,    w_iso_nxt;
    logic            r_ready,  w_ready_nxt;
    logic            r_busy,   w_busy_nxt;

    logic [c_CW-1:0] w_cost;
    logic [IW-1:0]   w_idx_up;
    logic [IW-1:0]   w_idx_dn;

    // Per-index dwell: an enabled segment settles, a masked one is skipped
    // in a single cycle.
    assign w_cost   = r_mask[r_idx] ? c_SETTLE : c_ONE;
    assign w_idx_up = r_idx + IW'(1);
    assign w_idx_dn = r_idx - IW'(1);

    // State register: all outputs are registered copies of the next values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_ST_OFF;
            r_mask   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_seg_on <= '0;
            r_iso    <= '1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_seg_on <= w_seg_on_nxt;
            r_iso    <= w_iso_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode. In UP/DOWN, r_cnt == 0 marks an index
    // whose entry edge is still pending (first index after OFF, first index
    // after ISO_ASSERT); later indices are entered on the same edge that
    // completes the previous index's dwell.
    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_seg_on_nxt = r_seg_on;
        w_iso_nxt    = r_iso;
        w_ready_nxt  = r_ready;

        case (r_state)
            c_ST_OFF: begin
                if (PWR_REQ) begin
                    w_mask_nxt  = SEG_MASK;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_UP;
                end
            end

            c_ST_UP: begin
                if (!PWR_REQ) begin
                    // Abort: no further rises, unwind from the current index.
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_ISO_ASSERT;
                end else if (r_cnt == c_ZERO) begin
                    w_seg_on_nxt[r_idx] = r_seg_on[r_idx] | r_mask[r_idx];
                    w_cnt_nxt           = c_ONE;
                end else if (r_cnt == w_cost) begin
                    if (r_idx == c_LAST) begin
                        w_cnt_nxt   = c_ONE;
                        w_state_nxt = c_ST_ISO_REL;
                    end else begin
                        w_idx_nxt              = w_idx_up;
                        w_seg_on_nxt[w_idx_up] = r_seg_on[w_idx_up] | r_mask[w_idx_up];
                        w_cnt_nxt              = c_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end

            c_ST_ISO_REL: begin
                if (!PWR_REQ) begin
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_ISO_ASSERT;
                end else if (r_cnt == c_ISO_DLY) begin
                    // Only powered segments leave isolation.
                    w_iso_nxt   = ~r_mask;
                    w_ready_nxt = 1'b1;
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end

            c_ST_ON: begin
                if (!PWR_REQ) begin
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_ISO_ASSERT;
                end
            end

            c_ST_ISO_ASSERT: begin
                // Isolation goes up before any switch opens; SEG_IDX is left
                // where the ramp stopped so DOWN unwinds from there.
                w_iso_nxt   = '1;
                w_ready_nxt = 1'b0;
                if (r_cnt == c_ISO_DLY_M1) begin
                    w_cnt_nxt   = c_ZERO;
                    w_state_nxt = c_ST_DOWN;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end

            c_ST_DOWN: begin
                if (r_cnt == c_ZERO) begin
                    w_seg_on_nxt[r_idx] = 1'b0;
                    w_cnt_nxt           = c_ONE;
                end else if (r_cnt == w_cost) begin
                    if (r_idx == c_IDX0) begin
                        w_cnt_nxt   = c_ZERO;
                        w_state_nxt = c_ST_OFF;
                    end else begin
                        w_idx_nxt              = w_idx_dn;
                        w_seg_on_nxt[w_idx_dn] = 1'b0;
                        w_cnt_nxt              = c_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = c_ZERO;
                w_state_nxt = c_ST_OFF;
            end
        endcase

        w_busy_nxt = !((w_state_nxt == c_ST_OFF) || (w_state_nxt == c_ST_ON));
    end

    assign SEG_ON  = r_seg_on;
    assign ISO     = r_iso;
    assign READY   = r_ready;
    assign BUSY    = r_busy;
    assign SEG_IDX = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_io__brkn_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf180mcu_fd_io__brkn_seq
// Description : Scoreboard bench for the ring power sequencer. A timeline
//               model computes event times per transaction and pushes the
//               expected outputs of every cycle; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_io__brkn_seq;

    localparam int P_NSEG   = 4;
    localparam int P_SETTLE = 3;
    localparam int P_ISO    = 2;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       PWR_REQ = 1'b0;
    logic [3:0] SEG_MASK = 4'b0000;
    logic [3:0] SEG_ON;
    logic [3:0] ISO;
    logic       READY;
    logic       BUSY;
    logic [1:0] SEG_IDX;

    gf180mcu_fd_io__brkn_seq #(
        .NSEG    (P_NSEG),
        .SETTLE  (P_SETTLE),
        .ISO_DLY (P_ISO)
    ) dut (
        .CLK      (clk),
        .RST      (RST),
        .PWR_REQ  (PWR_REQ),
        .SEG_MASK (SEG_MASK),
        .SEG_ON   (SEG_ON),
        .ISO      (ISO),
        .READY    (READY),
        .BUSY     (BUSY),
        .SEG_IDX  (SEG_IDX)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk4(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline reference model. Phases: 0 off, 1 ramping (incl. isolation
    // release wait), 2 on, 3 ramping down (incl. isolation assert wait).
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] seg;
        logic [3:0] iso;
        logic       rdy;
        logic       busy;
        logic [1:0] idx;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;

    int         m_phase = 0;
    logic [3:0] m_mask  = '0;
    longint     st[P_NSEG];
    longint     dn[P_NSEG];
    longint     rel_t, off_t, drop_t;
    int         cur;
    logic [3:0] on_drop, iso_drop;
    logic       rdy_drop;
    logic [3:0] e_seg = '0, e_iso = '1;
    logic       e_rdy = 1'b0, e_busy = 1'b0;
    logic [1:0] e_idx = '0;

    function automatic longint cost(input int i);
        return m_mask[i] ? longint'(P_SETTLE) : 64'd1;
    endfunction

    task automatic start_down(input longint n, input int c);
        longint t;
        drop_t   = n;
        cur      = c;
        on_drop  = e_seg;
        iso_drop = e_iso;
        rdy_drop = e_rdy;
        t = n + 1 + P_ISO;
        for (int i = c; i >= 0; i--) begin
            dn[i] = t;
            t += cost(i);
        end
        off_t   = t;
        m_phase = 3;
    endtask

    task automatic model_step(input longint n);
        longint t;
        if (RST) begin
            m_phase = 0;
            e_seg = '0; e_iso = '1; e_rdy = 1'b0; e_busy = 1'b0; e_idx = '0;
        end else begin
            case (m_phase)
                0: if (PWR_REQ) begin
                    m_mask = SEG_MASK;
                    t = n + 1;
                    for (int i = 0; i < P_NSEG; i++) begin
                        st[i] = t;
                        t += cost(i);
                    end
                    rel_t   = t + P_ISO;
                    m_phase = 1;
                end
                1: if (!PWR_REQ) start_down(n, int'(e_idx));
                   else if (n == rel_t) m_phase = 2;
                2: if (!PWR_REQ) start_down(n, P_NSEG - 1);
                3: if (n == off_t) m_phase = 0;
                default: m_phase = 0;
            endcase
            case (m_phase)
                1: begin
                    e_idx = '0;
                    for (int i = 0; i < P_NSEG; i++) begin
                        e_seg[i] = m_mask[i] && (st[i] <= n);
                        if (st[i] <= n) e_idx = 2'(i);
                    end
                    e_iso = '1; e_rdy = 1'b0; e_busy = 1'b1;
                end
                2: begin
                    e_seg = m_mask; e_iso = ~m_mask; e_rdy = 1'b1; e_busy = 1'b0;
                    e_idx = 2'(P_NSEG - 1);
                end
                3: begin
                    for (int i = 0; i < P_NSEG; i++)
                        e_seg[i] = on_drop[i] && !((i <= cur) && (dn[i] <= n));
                    e_iso  = (n >= drop_t + 1) ? 4'b1111 : iso_drop;
                    e_rdy  = (n >= drop_t + 1) ? 1'b0 : rdy_drop;
                    e_busy = 1'b1;
                    e_idx  = 2'(cur);
                    for (int i = cur; i >= 0; i--)
                        if (dn[i] <= n) e_idx = 2'(i);
                end
                default: begin
                    e_seg = '0; e_iso = '1; e_rdy = 1'b0; e_busy = 1'b0; e_idx = '0;
                end
            endcase
        end
    endtask

    // Stimulus side of the scoreboard: model the edge, push the expectation.
    always @(posedge clk) begin
        exp_t e;
        model_step(cyc);
        e.seg = e_seg; e.iso = e_iso; e.rdy = e_rdy; e.busy = e_busy; e.idx = e_idx;
        q.push_back(e);
        cyc++;
    end

    // Monitor: every cycle the DUT presents a registered output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk4("sb_seg_on", SEG_ON, e.seg);
            chk4("sb_iso",    ISO,    e.iso);
            chk1("sb_ready",  READY,  e.rdy);
            chk1("sb_busy",   BUSY,   e.busy);
            chk4("sb_seg_idx", {2'b00, SEG_IDX}, {2'b00, e.idx});
            chk4("inv_iso_implies_on", (~ISO) & (~SEG_ON), 4'b0000);
        end
    end

    task automatic wait_until(input longint target);
        while (cyc <= target) begin
            @(posedge clk);
            #1;
        end
    endtask

    longint e0, d0, e2, e3, e4;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk4("rst_seg_on", SEG_ON, 4'b0000);
        chk4("rst_iso", ISO, 4'b1111);
        chk1("rst_ready", READY, 1'b0);
        chk1("rst_busy", BUSY, 1'b0);
        chk4("rst_idx", {2'b00, SEG_IDX}, 4'b0000);
        @(negedge clk) RST = 1'b0;

        // Ramp-up, mask 1011; mask changes after acceptance must be ignored.
        @(negedge clk); PWR_REQ = 1'b1; SEG_MASK = 4'b1011; e0 = cyc;
        @(negedge clk); SEG_MASK = 4'b0100;
        wait_until(e0 + 1);  chk4("up_seg_e1", SEG_ON, 4'b0001); chk1("up_busy_e1", BUSY, 1'b1);
        wait_until(e0 + 4);  chk4("up_seg_e4", SEG_ON, 4'b0011);
        wait_until(e0 + 8);  chk4("up_seg_e8", SEG_ON, 4'b1011); chk4("up_iso_e8", ISO, 4'b1111);
        wait_until(e0 + 12); chk1("up_ready_e12", READY, 1'b0); chk1("up_busy_e12", BUSY, 1'b1);
        wait_until(e0 + 13); chk4("up_iso_e13", ISO, 4'b0100); chk1("up_ready_e13", READY, 1'b1);
        chk1("up_busy_e13", BUSY, 1'b0);

        // Ramp-down, with a re-request during DOWN that must wait for OFF.
        @(negedge clk); PWR_REQ = 1'b0; SEG_MASK = 4'b1011; d0 = cyc;
        wait_until(d0 + 1);  chk4("dn_iso_d1", ISO, 4'b1111); chk1("dn_ready_d1", READY, 1'b0);
        wait_until(d0 + 3);  chk4("dn_seg_d3", SEG_ON, 4'b0011);
        @(negedge clk); PWR_REQ = 1'b1;
        wait_until(d0 + 7);  chk4("dn_seg_d7", SEG_ON, 4'b0001);
        wait_until(d0 + 10); chk4("dn_seg_d10", SEG_ON, 4'b0000); chk1("dn_busy_d10", BUSY, 1'b1);
        wait_until(d0 + 13); chk1("dn_busy_d13", BUSY, 1'b0);
        e2 = d0 + 14;
        wait_until(e2);      chk1("rereq_busy", BUSY, 1'b1); chk4("rereq_seg", SEG_ON, 4'b0000);
        wait_until(e2 + 1);  chk4("rereq_seg_e1", SEG_ON, 4'b0001);

        // Abort sampled at E+5 while SEG_IDX = 1.
        wait_until(e2 + 4);
        @(negedge clk); PWR_REQ = 1'b0;
        wait_until(e2 + 8);  chk4("abort_seg_8", SEG_ON, 4'b0001); chk4("abort_iso_8", ISO, 4'b1111);
        wait_until(e2 + 11); chk4("abort_seg_11", SEG_ON, 4'b0000);
        wait_until(e2 + 13); chk1("abort_busy_13", BUSY, 1'b1);
        wait_until(e2 + 14); chk1("abort_busy_14", BUSY, 1'b0);

        // All-zero mask.
        @(negedge clk); PWR_REQ = 1'b1; SEG_MASK = 4'b0000; e3 = cyc;
        wait_until(e3 + 6);  chk1("zero_ready_6", READY, 1'b0);
        wait_until(e3 + 7);  chk1("zero_ready_7", READY, 1'b1);
        chk4("zero_iso_7", ISO, 4'b1111); chk4("zero_seg_7", SEG_ON, 4'b0000);
        @(negedge clk); PWR_REQ = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-ramp, then a fresh request.
        PWR_REQ = 1'b1; SEG_MASK = 4'b1011; e4 = cyc;
        wait_until(e4 + 4);  chk4("mid_seg_4", SEG_ON, 4'b0011);
        @(negedge clk); RST = 1'b1;
        wait_until(e4 + 5);
        chk4("mid_rst_seg", SEG_ON, 4'b0000); chk4("mid_rst_iso", ISO, 4'b1111);
        chk1("mid_rst_ready", READY, 1'b0);   chk1("mid_rst_busy", BUSY, 1'b0);
        @(negedge clk); RST = 1'b0;
        wait_until(e4 + 7);  chk4("post_rst_seg", SEG_ON, 4'b0001);

        // Randomised request toggling, mask churn and rare resets.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 4) PWR_REQ = ~PWR_REQ;
            SEG_MASK = 4'($urandom);
            RST = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk); RST = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_io__brkn_seq.md
Name: gf180mcu_fd_io__brkn_seq

Overview:
- Parametrised power-sequencing successor to the single-rail pad-ring break cell.
- Controls NSEG pad-ring segments separated by break cells.
- Ramps segment power switches on one at a time, spaced by a settle delay, then releases isolation.
- Powers down in reverse order with isolation asserted first. Sits in the IO ring control logic beside the break cells.

Parameters:
NSEG, 4, number of ring segments (1..16)
SETTLE, 16, cycles from a segment's SEG_ON change to the next segment's change (>=1)
ISO_DLY, 4, cycles between ramp end and isolation release, and between isolation assert and ramp-down start (>=1)
IW, derived clog2(NSEG) (min 1), index width (localparam)

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
PWR_REQ  input  1  level request: 1 = ring on, 0 = ring off
SEG_MASK  input  NSEG  segments to power; sampled only when leaving OFF
SEG_ON  output  NSEG  power-switch enables
ISO  output  NSEG  isolation per segment, 1 = isolated
READY  output  1  ring fully on, isolation released
BUSY  output  1  high in any state other than OFF and ON
SEG_IDX  output  IW  index currently being walked

Behaviour:
- Single clock; all state is updated on the CLK rising edge.
- Reset is synchronous, active-high, and overrides every other input.
- Reset values: state OFF, SEG_ON=0, ISO=all 1, READY=0, BUSY=0, SEG_IDX=0, mask_q=0, counter=0.
- All outputs are registered.
- States: OFF, UP, ISO_REL, ON, ISO_ASSERT, DOWN.
- OFF:
  - If PWR_REQ=1 is sampled at edge E: mask_q<=SEG_MASK, SEG_IDX<=0, go to UP.
  - Otherwise stay in OFF.
- UP, walking SEG_IDX from 0 to NSEG-1:
  - Enabled index: SEG_ON[idx] rises on entry, then the index holds for SETTLE cycles.
  - Masked-off index: costs 1 cycle and causes no SEG_ON change.
  - Enabled index t_i = E+1 + sum of costs of lower indices.
  - After index NSEG-1, go to ISO_REL.
- ISO_REL:
  - Wait ISO_DLY cycles.
  - Then ISO[i]<=0 for each mask_q[i]=1 and READY<=1 on the same edge, and go to ON.
  - Unmasked segments keep ISO=1.
- ON: hold. If PWR_REQ=0 is sampled at edge D, go to ISO_ASSERT.
- ISO_ASSERT:
  - ISO=all 1 and READY=0 at D+1.
  - Wait ISO_DLY cycles, then go to DOWN with SEG_IDX=NSEG-1.
- DOWN:
  - Reverse walk to index 0 with the same per-index costs.
  - SEG_ON[idx] falls on entry if it is currently set.
  - After index 0's cost completes, go to OFF with BUSY=0.
- Abort during UP or ISO_REL, with PWR_REQ=0 sampled at edge A:
  - No further SEG_ON rises.
  - ISO stays all 1. Go to ISO_ASSERT.
  - DOWN then starts at the current SEG_IDX rather than NSEG-1.
  - Indices above the current one are unpowered and are not walked.
- PWR_REQ=1 during ISO_ASSERT or DOWN is ignored. The ramp-down completes to OFF, and the request is then re-sampled in OFF.
- SEG_MASK changes outside OFF are ignored.
- All-zero mask: the walk still runs, costing NSEG cycles. No SEG_ON rises. READY=1 at E+1+NSEG+ISO_DLY. ISO stays all 1.
- Reset mid-operation: the next edge returns all registers to their reset values. SEG_ON drops immediately for all segments with no reverse sequencing; the supply-side contract accepts this.
- BUSY=1 in UP, ISO_REL, ISO_ASSERT and DOWN.
- Invariant: ISO[i]=0 implies SEG_ON[i]=1, at every cycle.

Test Plan:
- Ramp-up: NSEG=4, SETTLE=3, ISO_DLY=2, SEG_MASK=4'b1011, PWR_REQ rises sampled at edge 0 -> SEG_ON[0]@1, SEG_ON[1]@4, SEG_ON[3]@8 with SEG_ON[2] never set; ISO=4'b0100 and READY=1 @13; BUSY high for edges 1..12.
- Ramp-down: same config in ON, PWR_REQ=0 sampled at edge D -> ISO=4'b1111 and READY=0 @D+1; SEG_ON[3] falls @D+3, [1] @D+7, [0] @D+10; BUSY=0 and state OFF @D+13.
- Abort: PWR_REQ drops, sampled at edge 5 during the previous ramp (SEG_IDX=1) -> no SEG_ON[3] rise, ISO stays all 1, SEG_ON[1] falls @8, SEG_ON[0] falls @11, OFF @14.
- All-zero mask with ISO_DLY=2 -> SEG_ON stays 0, ISO stays 4'b1111, READY=1 @7.
- RST=1 asserted mid-UP with SEG_ON=4'b0011 -> next edge: SEG_ON=0, ISO=4'b1111, READY=0, BUSY=0; a new request is accepted afterwards.
- Randomised REQ toggling: check the ISO/SEG_ON invariant every cycle, and that PWR_REQ=1 during DOWN is deferred until OFF.
